// File: rtl/mul_arb_pkg.sv
// Shared types and widths for the multiplier arbiter.
// Holds the controller state encoding and the operand/result widths.
package mul_arb_pkg;

    localparam int unsigned OP_W  = 8;
    localparam int unsigned RES_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_RUN,
        ST_RESP
    } state_t;

    // Index width for a requester vector, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: the first active request after the last grant wins.
module rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] grant_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             valid_c
);

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        // Offset N_REQ wraps back to the last grantee, so it ranks lowest.
        for (int k = 1; k <= int'(N_REQ); k++) begin
            int j;
            j = (int'(last) + k) % int'(N_REQ);
            if (!valid_c && req[IDX_W'(j)]) begin
                valid_c              = 1'b1;
                grant_c[IDX_W'(j)]   = 1'b1;
                idx_c                = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one multi-cycle multiplier between N_REQ requesters, one operation
// in flight, with start and run timeouts reported through rsp_err.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned START_TO = 4,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [OP_W*N_REQ-1:0] req_a,
    input  logic [OP_W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [RES_W-1:0]      rsp_result,
    output logic                  rsp_err,
    output logic [OP_W-1:0]       mul_a,
    output logic [OP_W-1:0]       mul_b,
    output logic                  mul_start,
    input  logic                  mul_busy,
    input  logic [RES_W-1:0]      mul_result
);

    localparam int unsigned IDX_W   = idx_width(N_REQ);
    localparam int unsigned CNT_MAX = (START_TO > TIMEOUT) ? START_TO : TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Counters hold the cycles already spent, so the limit is one below.
    localparam logic [CNT_W-1:0] START_LIM   = CNT_W'(START_TO - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;

    state_t           state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt_oh;
    logic [CNT_W-1:0] cnt;

    logic [N_REQ-1:0] arb_grant_c;
    logic [IDX_W-1:0] arb_idx_c;
    logic             arb_valid_c;
    logic [OP_W-1:0]  sel_a_c;
    logic [OP_W-1:0]  sel_b_c;
    logic [CNT_W-1:0] cnt_inc_c;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .last    (last_grant),
        .grant_c (arb_grant_c),
        .idx_c   (arb_idx_c),
        .valid_c (arb_valid_c)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_a_c = '0;
        sel_b_c = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (arb_grant_c[i]) begin
                sel_a_c = sel_a_c | req_a[i*OP_W +: OP_W];
                sel_b_c = sel_b_c | req_b[i*OP_W +: OP_W];
            end
        end
    end

    assign cnt_inc_c = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);

    // Controller: all outputs registered, so each is set on entry to its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= IDX_W'(N_REQ - 1);
            gnt_idx    <= '0;
            gnt_oh     <= '0;
            cnt        <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_start  <= 1'b0;
        end else begin
            req_ready <= '0;
            mul_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid_c) begin
                        gnt_idx   <= arb_idx_c;
                        gnt_oh    <= arb_grant_c;
                        req_ready <= arb_grant_c;
                        mul_a     <= sel_a_c;
                        mul_b     <= sel_b_c;
                        mul_start <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (mul_busy) begin
                        cnt   <= '0;
                        state <= ST_RUN;
                    end else if (cnt >= START_LIM) begin
                        rsp_err    <= 1'b1;
                        rsp_result <= '0;
                        rsp_valid  <= gnt_oh;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt_inc_c;
                    end
                end
                ST_RUN: begin
                    if (!mul_busy) begin
                        rsp_err    <= 1'b0;
                        rsp_result <= mul_result;
                        rsp_valid  <= gnt_oh;
                        state      <= ST_RESP;
                    end else if (cnt >= TIMEOUT_LIM) begin
                        rsp_err    <= 1'b1;
                        rsp_result <= '0;
                        rsp_valid  <= gnt_oh;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt_inc_c;
                    end
                end
                ST_RESP: begin
                    // Only the granted requester can retire the response.
                    if (rsp_ready[gnt_idx]) begin
                        rsp_valid  <= '0;
                        last_grant <= gnt_idx;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters.
REQ-002 SHALL have parameter START_TO, default 4, max cycles from mul_start until mul_busy rises.
REQ-003 SHALL have parameter TIMEOUT, default 64, max cycles mul_busy may stay high.
REQ-004 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  in  N_REQ  per-requester operation request.
REQ-007 SHALL have port req_a  in  8*N_REQ  operand A, requester i at bits [8i+7:8i].
REQ-008 SHALL have port req_b  in  8*N_REQ  operand B, same packing.
REQ-009 SHALL have port req_ready  out  N_REQ  one-hot accept pulse.
REQ-010 SHALL have port rsp_valid  out  N_REQ  one-hot response valid.
REQ-011 SHALL have port rsp_ready  in  N_REQ  per-requester response accept.
REQ-012 SHALL have port rsp_result  out  16  product, shared by all requesters.
REQ-013 SHALL have port rsp_err  out  1  timeout flag for current response.
REQ-014 SHALL have port mul_a, mul_b  out  8 each  operands to the shared multiplier.
REQ-015 SHALL have port mul_start  out  1  one-cycle start pulse to the multiplier.
REQ-016 SHALL have port mul_busy  in  1  multiplier busy.
REQ-017 SHALL have port mul_result  in  16  multiplier product.

Function
REQ-018 SHALL implement FSM IDLE, ISSUE, WAIT_BUSY, RUN, RESP; exactly one state active.
REQ-019 IDLE: if any req_valid, grant round-robin starting at last_grant+1 (mod N_REQ), pulse req_ready[g] one cycle, latch operands and g, go ISSUE; else stay.
REQ-020 ISSUE: mul_start=1 for exactly one cycle, mul_a/mul_b = latched operands, go WAIT_BUSY, clear cycle counter.
REQ-021 mul_a/mul_b SHALL be registered and stable from ISSUE through end of RUN.
REQ-022 WAIT_BUSY: mul_busy=1 -> RUN, counter cleared; counter reaches START_TO with no busy -> RESP, rsp_err=1, rsp_result=0.
REQ-023 RUN: mul_busy=0 -> capture mul_result into rsp_result, rsp_err=0, go RESP; counter reaches TIMEOUT -> RESP, rsp_err=1, rsp_result=0.
REQ-024 RESP: rsp_valid[g]=1, rsp_result/rsp_err held stable until rsp_ready[g]=1; that cycle update last_grant=g, go IDLE.
REQ-025 rsp_ready of non-granted requesters SHALL be ignored.
REQ-026 A requester SHALL hold req_valid and operands until req_ready; deasserting req_valid before grant withdraws the request without error.
REQ-027 New requests SHALL NOT be accepted outside IDLE; at most one operation in flight.
REQ-028 Request from requester g arriving while its own response is pending SHALL wait until IDLE and compete normally.
REQ-029 Latency accept-to-rsp_valid = 2 + busy-rise delay + busy duration cycles; minimum 1 idle cycle between successive grants.
REQ-030 Counters SHALL saturate and never wrap.

Reset
REQ-031 On rst: state=IDLE, last_grant=N_REQ-1 (requester 0 has first priority), all outputs 0, counters 0.
REQ-032 rst mid-operation SHALL abandon the operation with no response; multiplier shares the same rst.

Structure
REQ-033 Package mul_arb_pkg SHALL hold the state enum, operand width 8, result width 16.
REQ-034 Round-robin pick SHALL be sub-module rr_arbiter (request vector, last grant -> one-hot grant, valid).

Verification (bench uses behavioural multiplier: busy 15 cycles after start, 1-cycle rise)
REQ-035 req_valid[0], a=12, b=13 -> single mul_start, rsp_valid[0], rsp_result=156, rsp_err=0.
REQ-036 All four req_valid held from reset -> grants in order 0,1,2,3; results correct per requester.
REQ-037 req_valid[2], a=255, b=255 -> rsp_result=65025.
REQ-038 Model never raises busy -> rsp_err=1, rsp_result=0 after START_TO cycles in WAIT_BUSY.
REQ-039 rsp_ready low 10 cycles -> rsp_valid/rsp_result stable, no mul_start, no req_ready meanwhile.
REQ-040 rst during RUN -> all outputs 0 immediately; next request after rst completes correctly.
